alu_control_unit: RTL and testbench
===================================

# alu_control_unit

Sequencing controller for the 8-bit ALU datapath. It accepts an operation request, loads the operand registers, and drives the add/subtract/shift/restore strobes. It steps the shared 3-bit iteration counter (load, count-up), terminating iterative operations when the counter reaches 7. It implements 8-iteration radix-2 Booth multiplication and restoring division, plus single-pass add/sub.

## Interface
Parameters: none (constants live in the package).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `start` in 1: request pulse; sampled only in IDLE.
- `op` in 2: 00 add, 01 sub, 10 mul, 11 div; latched with `start`.
- `cnt` in 3: current iteration-counter value `q`.
- `q0_qm1` in 2: Booth pair {Q[0], Q[-1]}.
- `a_sign` in 1: sign bit of accumulator A.
- `m_zero` in 1: M register equals 0.
- `cnt_load` out 1: counter load (initial value 0).
- `cnt_up` out 1: counter increment.
- `ld_in` out 1: load A/Q/M from operand buses; clear A, Q[-1].
- `add_en` out 1: A ← A + M (or A ← X + Y for add).
- `sub_en` out 1: A ← A − M (or A ← X − Y for sub).
- `shift_en` out 1: mul: arithmetic right shift A:Q:Q[-1]; div: left shift A:Q.
- `restore_en` out 1: A ← A + M, Q[0] ← 0.
- `q0_set` out 1: Q[0] ← 1.
- `out_en` out 1: drive result registers onto output bus.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in OUT.
- `err` out 1: valid with `done`; divide-by-zero or unsupported op.

## Operation
- States: IDLE, LOAD, EXEC, EVAL, SHIFT, DSHIFT, DSUB, DCHECK, OUT.
- IDLE: `start`=1 latches `op` and moves to LOAD. `start` in any other state is ignored.
- LOAD: `ld_in`=1 and `cnt_load`=1.
  - add/sub → EXEC.
  - mul → EVAL.
  - div: `m_zero`=1 → OUT with err; otherwise → DSHIFT.
- EXEC: `add_en` or `sub_en` per op → OUT.
- EVAL: `q0_qm1`=10 → `sub_en`; 01 → `add_en`; 00/11 → no strobe. Next state SHIFT.
- SHIFT: `shift_en`=1, `cnt_up`=1. If `cnt`==7 (pre-increment value) → OUT, else → EVAL.
- DSHIFT: `shift_en`=1 → DSUB.
- DSUB: `sub_en`=1 → DCHECK.
- DCHECK: `cnt_up`=1. `a_sign`=1 → `restore_en`; else `q0_set`. If `cnt`==7 → OUT, else → DSHIFT.
- OUT: `out_en`=1, `done`=1, `err` per cause → IDLE.
- Strobes are mutually exclusive except `cnt_load`/`ld_in` and `cnt_up` with its partner strobe. `add_en`/`sub_en`/`restore_en`/`q0_set` depend combinationally on inputs (Mealy); all others decode from state only.
- Counter wrap 7→0 on the final `cnt_up` is expected and harmless; the next LOAD reloads it.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, op register 00. Every output is 0, including `busy`, `done` and `err`. Reset mid-operation aborts immediately with no further strobes.
- Latency is measured from the edge sampling `start` to the cycle in which `done`=1:
  - add/sub: 3 cycles.
  - mul: 18 cycles (LOAD + 8×2 + OUT).
  - div: 26 cycles (LOAD + 8×3 + OUT).
  - div-by-zero: 2 cycles.
- `busy` rises the cycle after `start` is sampled and falls the cycle after OUT.
- A new `start` may be accepted in the IDLE cycle immediately after OUT.
- The counter updates on the edge ending the cycle that asserts `cnt_up`. The termination test uses the value present during that cycle.

## Configuration
- `ALU_CTRL_DIV_EN` defined: division states and `m_zero` handling are compiled in, as above.
- `ALU_CTRL_DIV_EN` undefined: DSHIFT, DSUB and DCHECK are absent. `op`=11 goes LOAD → OUT with `err`=1 (done at 2 cycles), and `restore_en`/`q0_set` are tied 0.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the state encoding type;
  - op-code constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`;
  - `ITER_LAST`=3'd7.
- One sub-module, `alu_ctrl_decode`: purely combinational mapping of (state, op, `q0_qm1`, `a_sign`) to the strobes.
- The top module holds the state and op registers and the next-state logic.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles during a mul → all outputs 0, state IDLE. The next `start` with op=00 gives `done` at +3.
- Add: op=00, X=25, Y=17 → `ld_in` at +1, `add_en` at +2, `done` at +3 with `err`=0, result 42.
- Mul: op=10, Q=−3, M=7 → Booth strobe sequence matches `q0_qm1`; exactly 8 `cnt_up` pulses; `done` at +18; A:Q=−21.
- Div: op=11, Q=100, M=7 → 8 DCHECK cycles with the correct `restore_en`/`q0_set` pattern; `done` at +26; quotient 14, remainder 2.
- Div by zero: op=11, `m_zero`=1 → no `shift_en`; `done` and `err` at +2. With `ALU_CTRL_DIV_EN` undefined, any op=11 gives the same response.
- Start while busy: pulse `start` at +5 of a mul → ignored; single `done` at +18; re-`start` in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// Division states exist only when ALU_CTRL_DIV_EN is defined.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_EVAL,
    ST_SHIFT,
`ifdef ALU_CTRL_DIV_EN
    ST_DSHIFT,
    ST_DSUB,
    ST_DCHECK,
`endif
    ST_OUT
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] ITER_LAST = 3'd7;

  typedef struct packed {
    logic cnt_load;
    logic cnt_up;
    logic ld_in;
    logic add_en;
    logic sub_en;
    logic shift_en;
    logic restore_en;
    logic q0_set;
    logic out_en;
    logic busy;
    logic done;
  } strobes_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Request/status and datapath strobe bundle between the controller and the ALU datapath.
// Built with or without ALU_CTRL_DIV_EN; the signal set is the same either way.
interface alu_ctrl_if;
  import alu_ctrl_pkg::*;

  // Handshake: start is a one-cycle request honoured only while busy=0 (IDLE);
  // op is captured on that same edge. done pulses for exactly one cycle with err
  // valid alongside it, and busy drops the following cycle, when a new start may
  // already be presented.
  logic       start;
  logic [1:0] op;
  logic [2:0] cnt;
  logic [1:0] q0_qm1;
  logic       a_sign;
  logic       m_zero;

  logic       cnt_load;
  logic       cnt_up;
  logic       ld_in;
  logic       add_en;
  logic       sub_en;
  logic       shift_en;
  logic       restore_en;
  logic       q0_set;
  logic       out_en;
  logic       busy;
  logic       done;
  logic       err;
  state_e     state;

  modport slave (
    input  start, op, cnt, q0_qm1, a_sign, m_zero,
    output cnt_load, cnt_up, ld_in, add_en, sub_en, shift_en, restore_en,
           q0_set, out_en, busy, done, err, state
  );

  modport master (
    output start, op, cnt, q0_qm1, a_sign, m_zero,
    input  cnt_load, cnt_up, ld_in, add_en, sub_en, shift_en, restore_en,
           q0_set, out_en, busy, done, err, state
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational strobe decode from controller state, latched op and datapath flags.
// Division strobes (restore_en/q0_set) exist only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [1:0] op,
  input  logic [1:0] q0_qm1,
  input  logic       a_sign,
  output strobes_t   strb
);

`ifndef ALU_CTRL_DIV_EN
  logic unused_a_sign;
  assign unused_a_sign = a_sign;
`endif

  always_comb begin
    strb = '0;
    unique case (state)
      ST_IDLE: ;
      ST_LOAD: begin
        strb.ld_in    = 1'b1;
        strb.cnt_load = 1'b1;
      end
      ST_EXEC: begin
        strb.add_en = (op == OP_ADD);
        strb.sub_en = (op == OP_SUB);
      end
      // Booth recoding: 10 starts a run of ones (subtract), 01 ends one (add).
      ST_EVAL: begin
        strb.sub_en = (q0_qm1 == 2'b10);
        strb.add_en = (q0_qm1 == 2'b01);
      end
      ST_SHIFT: begin
        strb.shift_en = 1'b1;
        strb.cnt_up   = 1'b1;
      end
`ifdef ALU_CTRL_DIV_EN
      ST_DSHIFT: strb.shift_en = 1'b1;
      ST_DSUB:   strb.sub_en   = 1'b1;
      ST_DCHECK: begin
        strb.cnt_up     = 1'b1;
        strb.restore_en = a_sign;
        strb.q0_set     = ~a_sign;
      end
`endif
      ST_OUT: begin
        strb.out_en = 1'b1;
        strb.done   = 1'b1;
      end
      default: ;
    endcase
    strb.busy = (state != ST_IDLE);
  end

endmodule

// File: rtl/alu_control_unit.sv
// Sequencing controller for the 8-bit ALU: add/sub, Booth multiply, restoring divide.
// Define ALU_CTRL_DIV_EN to build the division path; otherwise op=11 returns err.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  alu_ctrl_if.slave bus
);

  state_e     state, state_nxt;
  logic [1:0] op_q;
  logic       err_q;
  logic       load_err;
  strobes_t   strb;

`ifdef ALU_CTRL_DIV_EN
  assign load_err = (op_q == OP_DIV) && bus.m_zero;
`else
  logic unused_m_zero;
  assign unused_m_zero = bus.m_zero;
  assign load_err      = (op_q == OP_DIV);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= OP_ADD;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.start) op_q <= bus.op;
      // The error cause is settled in LOAD and held until the OUT cycle.
      if (state == ST_LOAD) err_q <= load_err;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        unique case (op_q)
          OP_ADD, OP_SUB: state_nxt = ST_EXEC;
          OP_MUL:         state_nxt = ST_EVAL;
`ifdef ALU_CTRL_DIV_EN
          OP_DIV:         state_nxt = bus.m_zero ? ST_OUT : ST_DSHIFT;
`else
          OP_DIV:         state_nxt = ST_OUT;
`endif
          default:        state_nxt = ST_OUT;
        endcase
      end
      ST_EXEC:  state_nxt = ST_OUT;
      ST_EVAL:  state_nxt = ST_SHIFT;
      // Termination uses the counter value before this cycle's increment.
      ST_SHIFT: state_nxt = (bus.cnt == ITER_LAST) ? ST_OUT : ST_EVAL;
`ifdef ALU_CTRL_DIV_EN
      ST_DSHIFT: state_nxt = ST_DSUB;
      ST_DSUB:   state_nxt = ST_DCHECK;
      ST_DCHECK: state_nxt = (bus.cnt == ITER_LAST) ? ST_OUT : ST_DSHIFT;
`endif
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  alu_ctrl_decode u_decode (
    .state  (state),
    .op     (op_q),
    .q0_qm1 (bus.q0_qm1),
    .a_sign (bus.a_sign),
    .strb   (strb)
  );

  assign bus.cnt_load   = strb.cnt_load;
  assign bus.cnt_up     = strb.cnt_up;
  assign bus.ld_in      = strb.ld_in;
  assign bus.add_en     = strb.add_en;
  assign bus.sub_en     = strb.sub_en;
  assign bus.shift_en   = strb.shift_en;
  assign bus.restore_en = strb.restore_en;
  assign bus.q0_set     = strb.q0_set;
  assign bus.out_en     = strb.out_en;
  assign bus.busy       = strb.busy;
  assign bus.done       = strb.done;
  assign bus.err        = (state == ST_OUT) && err_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a behavioural 8-bit datapath model.
// Division checks follow ALU_CTRL_DIV_EN as the design does.
module tb_alu_control_unit;
  import alu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_if bus ();

  alu_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] got);
    logic [15:0] exp;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {16'd0, got}, {16'd0, exp});
    end
  endtask

  // ---------------- datapath model ----------------
  logic [7:0] dp_a = '0, dp_q = '0, dp_m = '0;
  logic       dp_qm1 = 1'b0;
  logic [2:0] dp_cnt = '0;
  logic [7:0] x_in = '0, y_in = '0;
  logic [1:0] cur_op = OP_ADD;

  assign bus.cnt    = dp_cnt;
  assign bus.q0_qm1 = {dp_q[0], dp_qm1};
  assign bus.a_sign = dp_a[7];
  assign bus.m_zero = (y_in == 8'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      dp_cnt <= '0;
    end else begin
      if (bus.cnt_load) dp_cnt <= 3'd0;
      else if (bus.cnt_up) dp_cnt <= dp_cnt + 3'd1;
      if (bus.ld_in) begin
        dp_a <= '0; dp_q <= x_in; dp_m <= y_in; dp_qm1 <= 1'b0;
      end else if (bus.add_en) begin
        dp_a <= (cur_op == OP_ADD) ? dp_q + dp_m : dp_a + dp_m;
      end else if (bus.sub_en) begin
        dp_a <= (cur_op == OP_SUB) ? dp_q - dp_m : dp_a - dp_m;
      end else if (bus.shift_en) begin
        if (cur_op == OP_MUL) {dp_a, dp_q, dp_qm1} <= {dp_a[7], dp_a, dp_q};
        else                  {dp_a, dp_q} <= {dp_a[6:0], dp_q, 1'b0};
      end else if (bus.restore_en) begin
        dp_a <= dp_a + dp_m; dp_q[0] <= 1'b0;
      end else if (bus.q0_set) begin
        dp_q[0] <= 1'b1;
      end
    end
  end

  // ---------------- output capture ----------------
  localparam int B_CLD = 11, B_CUP = 10, B_LD = 9, B_ADD = 8, B_SUB = 7, B_SH = 6;
  localparam int B_RST = 5, B_QS = 4, B_OE = 3, B_BSY = 2, B_DN = 1, B_ER = 0;

  function automatic logic [11:0] outs();
    return {bus.cnt_load, bus.cnt_up, bus.ld_in, bus.add_en, bus.sub_en, bus.shift_en,
            bus.restore_en, bus.q0_set, bus.out_en, bus.busy, bus.done, bus.err};
  endfunction

  logic [11:0] rec[0:40];
  int done_at;

  // Cycle +t is sampled at the t-th falling edge after the edge that sampled start.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input int inject_at);
    @(negedge clk);
    check_eq("idle_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("idle_done", {31'd0, bus.done}, 32'd0);
    cur_op = o; x_in = x; y_in = y;
    bus.op = o; bus.start = 1'b1;
    done_at = -1;
    for (int t = 0; t <= 40; t++) rec[t] = '0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      bus.start = (t == inject_at);
      if (t == inject_at) bus.op = OP_ADD;
      rec[t] = outs();
      if (bus.done) begin
        done_at = t;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    for (int t = 1; t <= 40; t++) n += int'(rec[t][b]);
    return n;
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0]  pat_a, pat_b;
  logic [11:0] acc;

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_ADD;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {20'd0, outs()}, 32'd0);
    check_eq("rst_state", {28'd0, bus.state}, {28'd0, ST_IDLE});
    rst_n = 1'b1;

    // Reset in the middle of a multiply
    @(negedge clk);
    cur_op = OP_MUL; x_in = 8'hFD; y_in = 8'd7;
    bus.op = OP_MUL; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check_eq("mid_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_outs1", {20'd0, outs()}, 32'd0);
    @(negedge clk);
    check_eq("abort_outs2", {20'd0, outs()}, 32'd0);
    check_eq("abort_state", {28'd0, bus.state}, {28'd0, ST_IDLE});
    rst_n = 1'b1;
    acc = '0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | outs();
    end
    check_eq("abort_quiet", {20'd0, acc}, 32'd0);

    // Add 25 + 17
    exp_q.push_back(16'd42);
    run_op(OP_ADD, 8'd25, 8'd17, 0);
    check_eq("add_ld", {30'd0, rec[1][B_LD], rec[1][B_CLD]}, 32'd3);
    check_eq("add_en", {31'd0, rec[2][B_ADD]}, 32'd1);
    check_eq("add_lat", done_at, 32'd3);
    check_eq("add_err", {30'd0, rec[3][B_ER], rec[3][B_OE]}, 32'd1);
    check_result("add_res", {8'd0, dp_a});

    // Sub 25 - 17
    exp_q.push_back(16'd8);
    run_op(OP_SUB, 8'd25, 8'd17, 0);
    check_eq("sub_en", {30'd0, rec[2][B_SUB], rec[2][B_ADD]}, 32'd2);
    check_eq("sub_lat", done_at, 32'd3);
    check_result("sub_res", {8'd0, dp_a});

    // Multiply -3 * 7: Booth pairs give sub, add, sub, then five idle evaluations
    exp_q.push_back(16'hFFEB);
    run_op(OP_MUL, 8'hFD, 8'd7, 0);
    pat_a = '0; pat_b = '0;
    for (int k = 1; k <= 8; k++) begin
      pat_a[k-1] = rec[2*k][B_ADD];
      pat_b[k-1] = rec[2*k][B_SUB];
    end
    check_eq("mul_add_pat", {24'd0, pat_a}, 32'h02);
    check_eq("mul_sub_pat", {24'd0, pat_b}, 32'h05);
    check_eq("mul_cnt_up", count_bit(B_CUP), 32'd8);
    check_eq("mul_shifts", count_bit(B_SH), 32'd8);
    check_eq("mul_lat", done_at, 32'd18);
    check_eq("mul_err", {31'd0, rec[18][B_ER]}, 32'd0);
    check_result("mul_res", {dp_a, dp_q});

`ifdef ALU_CTRL_DIV_EN
    // Divide 100 / 7: quotient bits MSB first 00001110, restores on the zeros
    exp_q.push_back({8'd2, 8'd14});
    run_op(OP_DIV, 8'd100, 8'd7, 0);
    pat_a = '0; pat_b = '0;
    for (int k = 1; k <= 8; k++) begin
      pat_a = {pat_a[6:0], rec[1+3*k][B_QS]};
      pat_b = {pat_b[6:0], rec[1+3*k][B_RST]};
    end
    check_eq("div_qset_pat", {24'd0, pat_a}, 32'h0E);
    check_eq("div_rest_pat", {24'd0, pat_b}, 32'hF1);
    check_eq("div_cnt_up", count_bit(B_CUP), 32'd8);
    check_eq("div_lat", done_at, 32'd26);
    check_eq("div_err", {31'd0, rec[26][B_ER]}, 32'd0);
    check_result("div_res", {dp_a, dp_q});
`else
    // Without division hardware any divide is rejected
    run_op(OP_DIV, 8'd100, 8'd7, 0);
    check_eq("nodiv_lat", done_at, 32'd2);
    check_eq("nodiv_err", {31'd0, rec[2][B_ER]}, 32'd1);
    check_eq("nodiv_shifts", count_bit(B_SH), 32'd0);
`endif

    // Divide by zero
    run_op(OP_DIV, 8'd100, 8'd0, 0);
    check_eq("dz_lat", done_at, 32'd2);
    check_eq("dz_err", {31'd0, rec[2][B_ER]}, 32'd1);
    check_eq("dz_shifts", count_bit(B_SH), 32'd0);
    check_eq("dz_strobes", count_bit(B_RST) + count_bit(B_QS) + count_bit(B_CUP), 32'd0);

    // Start while busy is ignored; restart right after OUT is accepted
    exp_q.push_back(16'hFFEB);
    run_op(OP_MUL, 8'hFD, 8'd7, 5);
    check_eq("inj_lat", done_at, 32'd18);
    check_eq("inj_err", {31'd0, rec[18][B_ER]}, 32'd0);
    check_result("inj_res", {dp_a, dp_q});
    exp_q.push_back(16'd3);
    run_op(OP_ADD, 8'd1, 8'd2, 0);
    check_eq("restart_lat", done_at, 32'd3);
    check_result("restart_res", {8'd0, dp_a});

    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
